axist_rx_checker: RTL and testbench

Self-checking AXI-Stream receive checker for the GPIO loopback examples. It sits downstream of the follower-side AXI-ST receive interface and alongside the leader-side pattern generator. Every transmitted beat is queued in an expected-data FIFO and compared with the received beat. The block captures the first and last beats of both streams and exposes them, plus pass/done/align status, through a 32-bit word-addressed read port behind the AVMM CSR decoder.

---
 rtl/axist_rx_checker.sv | 213 +++++++++++++++++++++
 tb/tb_axist_rx_checker.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axist_rx_checker.sv
// axist_rx_checker: AXI-Stream loopback checker. Every transmitted beat is
// queued in an expected-data FIFO and compared with the received stream.
// First/last beats of both streams and the run status are exposed through a
// 32-bit word-addressed read port.
// Build option: define AXIST_CHK_MISMATCH_CNT_EN to add a 16-bit saturating
// mismatch counter readable at 0x3F8 (reads 0 when not defined).
module axist_rx_checker #(
  parameter int unsigned AXI_TDATA_FACTOR = 4,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                           wr_clk,
  input  logic                           wr_rst,
  input  logic                           i_start,
  input  logic [7:0]                     i_pkt_cnt,
  input  logic [64*AXI_TDATA_FACTOR-1:0] i_tx_data,
  input  logic                           i_tx_valid,
  input  logic                           i_tx_ready,
  input  logic [64*AXI_TDATA_FACTOR-1:0] i_rx_data,
  input  logic                           i_rx_valid,
  output logic                           o_rx_ready,
  input  logic                           i_rd_en,
  input  logic [9:0]                     i_rd_addr,
  output logic [31:0]                    o_rd_data,
  output logic                           o_rd_valid,
  output logic                           o_done,
  output logic                           o_pass
);

  localparam int unsigned DW     = 64 * AXI_TDATA_FACTOR;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CW     = 9;
  localparam int unsigned NWORDS = 2 * AXI_TDATA_FACTOR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   n_beats;
  logic [CW-1:0]   tx_cnt;
  logic [CW-1:0]   rx_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [DW-1:0]   dout_first;
  logic [DW-1:0]   dout_last;
  logic [DW-1:0]   din_first;
  logic [DW-1:0]   din_last;
  logic            aligned;
  logic            mismatch;
  logic            overflow;
  logic            underflow;

  logic            run_c;
  logic            empty_c;
  logic            full_c;
  logic [DW-1:0]   head_c;
  logic            push_c;
  logic            pop_c;
  logic            write_c;
  logic            beat_ok_c;
  logic            bad_c;
  logic            last_rx_c;
  logic            aligned_nxt_c;
  logic            mismatch_nxt_c;
  logic            overflow_nxt_c;
  logic            underflow_nxt_c;
  logic            done_nxt_c;
  logic            pass_nxt_c;
  logic [5:0]      rd_idx_c;
  logic [31:0]     rd_word_c;
  logic [31:0]     mis_cnt_word_c;

  // The checker never back-pressures the receive stream.
  assign o_rx_ready = 1'b1;

  // Handshake decode, FIFO status and next values of the sticky flags.
  always_comb begin
    run_c           = (state == ST_RUN) && !i_start && !wr_rst;
    empty_c         = (wr_ptr == rd_ptr);
    full_c          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head_c          = fifo_mem[rd_ptr[AW-1:0]];
    push_c          = run_c && i_tx_valid && i_tx_ready && (tx_cnt < n_beats);
    pop_c           = run_c && i_rx_valid;
    write_c         = push_c && (!full_c || pop_c);
    beat_ok_c       = !empty_c && (head_c == i_rx_data);
    bad_c           = pop_c && !beat_ok_c;
    last_rx_c       = pop_c && ((rx_cnt + CW'(1)) == n_beats);
    aligned_nxt_c   = (pop_c && (rx_cnt == '0)) ? beat_ok_c : aligned;
    mismatch_nxt_c  = mismatch | bad_c;
    overflow_nxt_c  = overflow | (push_c && full_c && !pop_c);
    underflow_nxt_c = underflow | (pop_c && empty_c);
    done_nxt_c      = (state == ST_DONE) || last_rx_c;
    pass_nxt_c      = done_nxt_c && aligned_nxt_c && !mismatch_nxt_c &&
                      !overflow_nxt_c && !underflow_nxt_c;
  end

  // Expected-data storage; contents are qualified by the pointers only.
  always_ff @(posedge wr_clk) begin
    if (write_c) begin
      fifo_mem[wr_ptr[AW-1:0]] <= i_tx_data;
    end
  end

  // Run FSM, counters, pointers, captures and status flags.
  always_ff @(posedge wr_clk) begin
    if (wr_rst || i_start) begin
      state      <= wr_rst ? ST_IDLE : ST_RUN;
      n_beats    <= wr_rst ? '0 : (CW'(i_pkt_cnt) + CW'(1));
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_first <= '0;
      dout_last  <= '0;
      din_first  <= '0;
      din_last   <= '0;
      aligned    <= 1'b0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
    end else begin
      if (push_c) begin
        tx_cnt    <= tx_cnt + CW'(1);
        dout_last <= i_tx_data;
        if (tx_cnt == '0) begin
          dout_first <= i_tx_data;
        end
      end
      if (write_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rx_cnt   <= rx_cnt + CW'(1);
        din_last <= i_rx_data;
        if (rx_cnt == '0) begin
          din_first <= i_rx_data;
        end
        if (!empty_c) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
      if (last_rx_c) begin
        state <= ST_DONE;
      end
      aligned   <= aligned_nxt_c;
      mismatch  <= mismatch_nxt_c;
      overflow  <= overflow_nxt_c;
      underflow <= underflow_nxt_c;
      o_done    <= done_nxt_c;
      o_pass    <= pass_nxt_c;
    end
  end

`ifdef AXIST_CHK_MISMATCH_CNT_EN
  logic [15:0] mis_cnt;

  // Saturating count of bad received beats, including underflow pops.
  always_ff @(posedge wr_clk) begin
    if (wr_rst || i_start) begin
      mis_cnt <= '0;
    end else if (bad_c && (mis_cnt != 16'hFFFF)) begin
      mis_cnt <= mis_cnt + 16'd1;
    end
  end

  assign mis_cnt_word_c = {16'd0, mis_cnt};
`else
  assign mis_cnt_word_c = 32'd0;
`endif

  // Register map decode; unaligned or unmapped offsets read 0.
  always_comb begin
    rd_word_c = 32'd0;
    rd_idx_c  = i_rd_addr[7:2];
    if (i_rd_addr[1:0] == 2'b00) begin
      case (i_rd_addr[9:2])
        8'hFC:   rd_word_c = {27'd0, underflow, aligned, overflow, o_done, o_pass};
        8'hFD:   rd_word_c = {16'(rx_cnt), 16'(tx_cnt)};
        8'hFE:   rd_word_c = mis_cnt_word_c;
        default: begin
          if (32'(rd_idx_c) < NWORDS) begin
            case (i_rd_addr[9:8])
              2'd0:    rd_word_c = 32'(dout_first >> {rd_idx_c, 5'd0});
              2'd1:    rd_word_c = 32'(dout_last  >> {rd_idx_c, 5'd0});
              2'd2:    rd_word_c = 32'(din_first  >> {rd_idx_c, 5'd0});
              default: rd_word_c = 32'(din_last   >> {rd_idx_c, 5'd0});
            endcase
          end
        end
      endcase
    end
  end

  // One-cycle read latency; data holds between reads.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= 32'd0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_axist_rx_checker.sv
// tb_axist_rx_checker: randomized bench for axist_rx_checker with an
// event-level reference model (queue of expected beats plus sticky flags).
`timescale 1ns/1ps
module tb_axist_rx_checker;

  localparam int unsigned F     = 4;
  localparam int unsigned DW    = 64 * F;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NW    = 2 * F;

  logic          wr_clk = 1'b0;
  logic          wr_rst;
  logic          i_start;
  logic [7:0]    i_pkt_cnt;
  logic [DW-1:0] i_tx_data;
  logic          i_tx_valid;
  logic          i_tx_ready;
  logic [DW-1:0] i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic          i_rd_en;
  logic [9:0]    i_rd_addr;
  logic [31:0]   o_rd_data;
  logic          o_rd_valid;
  logic          o_done;
  logic          o_pass;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_run, m_done, m_aligned, m_mis, m_ovf, m_udf;
  int            m_n, m_txc, m_rxc, m_miscnt;
  logic [DW-1:0] m_dout_first, m_dout_last, m_din_first, m_din_last;

  axist_rx_checker #(.AXI_TDATA_FACTOR(F), .FIFO_DEPTH(DEPTH)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .i_start(i_start), .i_pkt_cnt(i_pkt_cnt),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .i_tx_ready(i_tx_ready),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_done(o_done), .o_pass(o_pass)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_clear(input bit run, input int n);
    q.delete();
    m_run = run; m_done = 0; m_aligned = 0; m_mis = 0; m_ovf = 0; m_udf = 0;
    m_n = n; m_txc = 0; m_rxc = 0; m_miscnt = 0;
    m_dout_first = '0; m_dout_last = '0; m_din_first = '0; m_din_last = '0;
  endfunction

  // One cycle of traffic: rx is judged against the queue head, then tx joins the queue.
  function automatic void model_beat(input bit txv, input logic [DW-1:0] txd,
                                     input bit rxv, input logic [DW-1:0] rxd);
    int occ;
    bit bad;
    logic [DW-1:0] head;
    if (!m_run) return;
    occ = q.size();
    if (rxv) begin
      if (occ == 0) begin
        m_udf = 1; bad = 1;
        if (m_rxc == 0) m_aligned = 0;
      end else begin
        head = q.pop_front();
        bad = (head !== rxd);
        if (m_rxc == 0) m_aligned = !bad;
      end
      if (bad) begin
        m_mis = 1;
        if (m_miscnt < 65535) m_miscnt++;
      end
      if (m_rxc == 0) m_din_first = rxd;
      m_din_last = rxd;
      m_rxc++;
    end
    if (txv && m_txc < m_n) begin
      if (m_txc == 0) m_dout_first = txd;
      m_dout_last = txd;
      m_txc++;
      if (occ == DEPTH && !rxv) m_ovf = 1;
      else q.push_back(txd);
    end
    if (m_rxc == m_n) begin
      m_done = 1; m_run = 0;
    end
  endfunction

  function automatic logic [31:0] exp_read(input logic [9:0] a);
    int k;
    logic [31:0] st;
    st = {27'd0, m_udf, m_aligned, m_ovf, m_done,
          m_done & m_aligned & ~m_mis & ~m_ovf & ~m_udf};
    if (a[1:0] != 2'b00) return 32'd0;
    if (a == 10'h3F0) return st;
    if (a == 10'h3F4) return {16'(m_rxc), 16'(m_txc)};
    if (a == 10'h3F8) begin
`ifdef AXIST_CHK_MISMATCH_CNT_EN
      return 32'(m_miscnt);
`else
      return 32'd0;
`endif
    end
    k = int'(a[7:2]);
    if (k >= NW) return 32'd0;
    case (a[9:8])
      2'd0:    return m_dout_first[32*k +: 32];
      2'd1:    return m_dout_last[32*k +: 32];
      2'd2:    return m_din_first[32*k +: 32];
      default: return m_din_last[32*k +: 32];
    endcase
  endfunction

  task automatic step(input bit start, input logic [7:0] pc, input bit txv,
                      input logic [DW-1:0] txd, input bit rxv, input logic [DW-1:0] rxd);
    int r;
    @(negedge wr_clk);
    i_start = start; i_pkt_cnt = pc; i_tx_data = txd;
    i_rx_valid = rxv; i_rx_data = rxd; i_rd_en = 1'b0;
    if (txv) begin
      i_tx_valid = 1'b1; i_tx_ready = 1'b1;
    end else begin
      r = $urandom_range(0, 2);
      i_tx_valid = (r == 1); i_tx_ready = (r != 1);
    end
    @(posedge wr_clk);
    if (start) model_clear(1, int'(pc) + 1);
    else model_beat(txv, txd, rxv, rxd);
  endtask

  task automatic idle();
    @(negedge wr_clk);
    i_start = 1'b0; i_tx_valid = 1'b0; i_rx_valid = 1'b0; i_rd_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d, output logic v);
    @(negedge wr_clk);
    i_start = 1'b0; i_tx_valid = 1'b0; i_rx_valid = 1'b0;
    i_rd_en = 1'b1; i_rd_addr = a;
    @(negedge wr_clk);
    i_rd_en = 1'b0;
    d = o_rd_data; v = o_rd_valid;
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    wr_rst = 1'b1; i_start = 1'b0; i_tx_valid = 1'b0; i_rx_valid = 1'b0; i_rd_en = 1'b0;
    @(negedge wr_clk);
    wr_rst = 1'b0;
    model_clear(0, 0);
  endtask

  // Loopback run: rx replays each tx beat 3 cycles later, optional corruption of one rx beat.
  task automatic run_loop(input logic [7:0] pc, input int stop_at, input int bad_idx,
                          input logic [DW-1:0] bad_mask, output bit ok);
    logic [DW-1:0] dd [3];
    bit dv [3];
    int sent, rxn, n;
    bit tv;
    logic [DW-1:0] td, rxd;
    n = int'(pc) + 1; sent = 0; rxn = 0; ok = 0;
    for (int i = 0; i < 3; i++) begin dv[i] = 0; dd[i] = '0; end
    step(1'b1, pc, 1'b0, '0, 1'b0, '0);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tv  = (sent < n) && ($urandom_range(0, 3) != 0);
      td  = rand_beat();
      rxd = dv[2] ? dd[2] : rand_beat();
      if (dv[2] && rxn == bad_idx) rxd = rxd ^ bad_mask;
      step(1'b0, pc, tv, td, dv[2], rxd);
      if (dv[2]) rxn++;
      if (tv) sent++;
      dd[2] = dd[1]; dv[2] = dv[1]; dd[1] = dd[0]; dv[1] = dv[0]; dd[0] = td; dv[0] = tv;
      if (m_done || (stop_at >= 0 && sent >= stop_at)) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    do_reset();
    checks++;
    if (o_done !== 1'b0 || o_pass !== 1'b0 || o_rd_valid !== 1'b0 ||
        o_rd_data !== 32'd0 || o_rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: done=%b pass=%b rd_valid=%b rd_data=%h rx_ready=%b, expected 0 0 0 0 1",
               o_done, o_pass, o_rd_valid, o_rd_data, o_rx_ready);
    end
    rd(10'h3F0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL reset_status: valid=%b data=%h, expected 1 00000000", v, d);
    end
    rd(10'h3F4, d, v);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL reset_counts: got %h expected 00000000", d);
    end
  endtask

  task automatic test_clean_loopback();
    logic [31:0] a, b; logic v; bit ok;
    run_loop(8'hFF, -1, -1, '0, ok);
    idle();
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_timeout: run did not complete, rx_cnt=%0d", m_rxc); end
    checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b1) begin
      errors++; $display("FAIL clean_flags: done=%b pass=%b expected 1 1", o_done, o_pass);
    end
    rd(10'h3F0, a, v);
    checks++;
    if (v !== 1'b1 || a !== 32'h0B || a !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL clean_status: got %h expected 0000000b", a);
    end
    rd(10'h3F4, a, v);
    checks++;
    if (a !== 32'h01000100) begin
      errors++; $display("FAIL clean_counts: got %h expected 01000100", a);
    end
    for (int k = 0; k < NW; k++) begin
      rd(10'(4 * k), a, v);
      rd(10'(10'h200 + 4 * k), b, v);
      checks++;
      if (a !== b || a !== exp_read(10'(4 * k))) begin
        errors++; $display("FAIL clean_first_word%0d: dout=%h din=%h model=%h", k, a, b, exp_read(10'(4 * k)));
      end
      rd(10'(10'h100 + 4 * k), a, v);
      rd(10'(10'h300 + 4 * k), b, v);
      checks++;
      if (a !== b || a !== exp_read(10'(10'h100 + 4 * k))) begin
        errors++; $display("FAIL clean_last_word%0d: dout=%h din=%h model=%h", k, a, b, exp_read(10'(10'h100 + 4 * k)));
      end
    end
  endtask

  task automatic test_single_bit();
    logic [31:0] d; logic v; bit ok;
    logic [DW-1:0] mask;
    mask = '0; mask[0] = 1'b1;
    run_loop(8'hFF, -1, 100, mask, ok);
    idle();
    checks++;
    if (!ok || o_pass !== 1'b0 || o_done !== 1'b1) begin
      errors++; $display("FAIL bitflip_flags: ok=%0d done=%b pass=%b expected 1 1 0", ok, o_done, o_pass);
    end
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h0A || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL bitflip_status: got %h expected 0000000a", d);
    end
    rd(10'h3F8, d, v);
    checks++;
`ifdef AXIST_CHK_MISMATCH_CNT_EN
    if (d !== 32'd1) begin errors++; $display("FAIL bitflip_miscnt: got %h expected 00000001", d); end
`else
    if (d !== 32'd0) begin errors++; $display("FAIL bitflip_miscnt: got %h expected 00000000", d); end
`endif
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic v; bit ok;
    logic [DW-1:0] mask;
    mask = '0; mask[DW-1] = 1'b1;
    run_loop(8'd7, -1, 0, mask, ok);
    rd(10'h3F0, d, v);
    checks++;
    if (!ok || d[3] !== 1'b0 || d !== 32'h02 || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL misalign_status: ok=%0d got %h expected 00000002", ok, d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic v;
    logic [DW-1:0] beats[$];
    logic [DW-1:0] b;
    step(1'b1, 8'd31, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = rand_beat(); beats.push_back(b);
      step(1'b0, 8'd31, 1'b1, b, 1'b0, rand_beat());
    end
    rd(10'h3F0, d, v);
    checks++;
    if (d[2] !== 1'b1 || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL ovf_status: got %h expected %h", d, exp_read(10'h3F0));
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'd31, 1'b0, rand_beat(), 1'b1, beats[i]);
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h0C || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL ovf_after_drain: got %h expected 0000000c", d);
    end
    rd(10'h3F4, d, v);
    checks++;
    if (d !== {16'd16, 16'd17}) begin
      errors++; $display("FAIL ovf_counts: got %h expected 00100011", d);
    end
    step(1'b0, 8'd31, 1'b0, rand_beat(), 1'b1, beats[DEPTH]);
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h1C || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL ovf_occupancy: got %h expected 0000001c", d);
    end
  endtask

  task automatic test_full_boundary();
    logic [31:0] d; logic v;
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] b, h;
    step(1'b1, 8'd63, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      b = rand_beat(); fifo.push_back(b);
      step(1'b0, 8'd63, 1'b1, b, 1'b0, rand_beat());
    end
    for (int i = 0; i < 10; i++) begin
      b = rand_beat(); h = fifo.pop_front(); fifo.push_back(b);
      step(1'b0, 8'd63, 1'b1, b, 1'b1, h);
    end
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h08 || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL full_simul_status: got %h expected 00000008", d);
    end
    rd(10'h3F4, d, v);
    checks++;
    if (d !== {16'd10, 16'd26}) begin
      errors++; $display("FAIL full_simul_counts: got %h expected 000a001a", d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      h = fifo.pop_front();
      step(1'b0, 8'd63, 1'b0, rand_beat(), 1'b1, h);
    end
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h08 || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL full_drain_status: got %h expected 00000008", d);
    end
    step(1'b0, 8'd63, 1'b0, rand_beat(), 1'b1, rand_beat());
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h18 || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL full_extra_pop: got %h expected 00000018", d);
    end
  endtask

  task automatic test_underflow();
    logic [31:0] d; logic v;
    logic [DW-1:0] b;
    b = rand_beat();
    step(1'b1, 8'd3, 1'b0, '0, 1'b0, '0);
    step(1'b0, 8'd3, 1'b1, b, 1'b1, b);
    step(1'b0, 8'd3, 1'b0, rand_beat(), 1'b1, b);
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h10 || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL udf_status: got %h expected 00000010", d);
    end
    rd(10'h3F4, d, v);
    checks++;
    if (d !== {16'd2, 16'd1}) begin
      errors++; $display("FAIL udf_counts: got %h expected 00020001", d);
    end
    rd(10'h3F8, d, v);
    checks++;
    if (d !== exp_read(10'h3F8)) begin
      errors++; $display("FAIL udf_miscnt: got %h expected %h", d, exp_read(10'h3F8));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v; bit ok;
    logic [9:0] addrs [8];
    logic [DW-1:0] b;
    b = rand_beat();
    step(1'b1, 8'd3, 1'b1, b, 1'b1, b);
    rd(10'h3F4, d, v);
    checks++;
    if (d !== 32'd0 || d !== exp_read(10'h3F4)) begin
      errors++; $display("FAIL start_discard: got %h expected 00000000", d);
    end
    run_loop(8'd3, -1, -1, '0, ok);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd3, 1'b1, rand_beat(), 1'b1, rand_beat());
    addrs = '{10'h3F0, 10'h3F4, 10'h020, 10'h002, 10'h3FC, 10'h104, 10'h31C, 10'h3F8};
    @(negedge wr_clk);
    i_start = 1'b0; i_tx_valid = 1'b0; i_rx_valid = 1'b0;
    i_rd_en = 1'b1; i_rd_addr = addrs[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge wr_clk);
      checks++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== exp_read(addrs[i])) begin
        errors++;
        $display("FAIL b2b_read addr=%h: valid=%b data=%h expected 1 %h", addrs[i], o_rd_valid, o_rd_data, exp_read(addrs[i]));
      end
      if (i < 7) i_rd_addr = addrs[i + 1];
      else i_rd_en = 1'b0;
    end
    @(negedge wr_clk);
    checks++;
    if (!ok || o_rd_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_valid_drop: ok=%0d valid=%b expected 0", ok, o_rd_valid);
    end
  endtask

  task automatic test_reset_restart();
    logic [31:0] d, e; logic v; bit ok;
    logic [9:0] a;
    logic [DW-1:0] b;
    run_loop(8'hFF, 50, -1, '0, ok);
    do_reset();
    checks++;
    if (!ok || o_done !== 1'b0 || o_pass !== 1'b0) begin
      errors++; $display("FAIL abort_flags: ok=%0d done=%b pass=%b expected 0 0", ok, o_done, o_pass);
    end
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) begin
        a = 10'(256 * r + 4 * k);
        rd(a, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL abort_read addr=%h: got %h expected 00000000", a, d); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      a = 10'(10'h3F0 + 4 * i);
      rd(a, d, v);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL abort_read addr=%h: got %h expected 00000000", a, d); end
    end
    b = rand_beat();
    step(1'b1, 8'd0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 8'd0, 1'b1, b, 1'b0, rand_beat());
    step(1'b0, 8'd0, 1'b0, rand_beat(), 1'b1, b);
    rd(10'h3F0, d, v);
    checks++;
    if (d !== 32'h0B || d !== exp_read(10'h3F0)) begin
      errors++; $display("FAIL restart_status: got %h expected 0000000b", d);
    end
    for (int k = 0; k < NW; k++) begin
      rd(10'(4 * k), d, v);
      rd(10'(10'h100 + 4 * k), e, v);
      checks++;
      if (d !== e || d !== b[32*k +: 32]) begin
        errors++; $display("FAIL restart_first_last%0d: first=%h last=%h expected %h", k, d, e, b[32*k +: 32]);
      end
    end
  endtask

  initial begin
    wr_rst = 1'b1; i_start = 1'b0; i_pkt_cnt = 8'd0; i_tx_data = '0; i_tx_valid = 1'b0;
    i_tx_ready = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_rd_en = 1'b0; i_rd_addr = '0;
    model_clear(0, 0);
    repeat (2) @(posedge wr_clk);
    test_reset();
    test_clean_loopback();
    test_single_bit();
    test_misalign();
    test_overflow();
    test_full_boundary();
    test_underflow();
    test_back_to_back();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
